oldland_bus_arbiter: RTL and testbench

Shares one word-addressed memory port between the pipeline's instruction bus and data bus. It sits between `oldland_pipeline` (or its caches/TLB front-ends) and the single external memory/bus slave. Arbitration is round-robin and non-preemptive: the grant locks to one requester until the slave returns ack or error. A bus-timeout counter converts a silent slave into an error to the requester.

---
 rtl/oldland_bus_pkg.sv | 14 +
 rtl/oldland_bus_timeout.sv | 39 +++
 rtl/oldland_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_oldland_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/oldland_bus_pkg.sv
// Shared definitions for the oldland bus arbiter and its helpers.
//   bus_state_e  : arbiter FSM state (idle, instruction owner, data owner)
//   TimeoutMax   : largest legal timeout in cycles, also the default
package oldland_bus_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StIbus = 2'd1,
    StDbus = 2'd2
  } bus_state_e;

  localparam int unsigned TimeoutMax = 255;

endpackage

// File: rtl/oldland_bus_timeout.sv
// 8-bit bus watchdog counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the count (takes priority over enable)
//   enable     : a busy cycle with no response; counts it
//   limit      : busy cycles allowed before expiry (1..255)
//   expired    : high during the limit-th consecutive enabled cycle
module oldland_bus_timeout (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (enable) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the busy cycles already elapsed, so the current cycle is number count_q + 1.
  assign expired = enable && !clear && (({1'b0, count_q} + 9'd1) == {1'b0, limit});

endmodule

// File: rtl/oldland_bus_arbiter.sv
// Round-robin, non-preemptive arbiter sharing one memory port between the instruction and
// data buses.
//   clk, rst_n            : clock, asynchronous active-low reset
//   i_access/i_addr       : instruction request; i_data/i_ack/i_error responses
//   d_access/d_addr/...   : data request with byte lanes and write data; d_* responses
//   m_*                   : shared slave port (registered request, combinational response)
//   owner_d               : high while the data bus owns the port
module oldland_bus_arbiter
  import oldland_bus_pkg::*;
#(
  parameter int unsigned timeout_cycles = TimeoutMax
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_access,
  input  logic [29:0] i_addr,
  output logic [31:0] i_data,
  output logic        i_ack,
  output logic        i_error,
  input  logic        d_access,
  input  logic [29:0] d_addr,
  input  logic [3:0]  d_bytesel,
  input  logic        d_wr_en,
  input  logic [31:0] d_wr_val,
  output logic [31:0] d_data,
  output logic        d_ack,
  output logic        d_error,
  output logic        m_access,
  output logic [29:0] m_addr,
  output logic [3:0]  m_bytesel,
  output logic        m_wr_en,
  output logic [31:0] m_wr_val,
  input  logic [31:0] m_data,
  input  logic        m_ack,
  input  logic        m_error,
  output logic        owner_d
);

  localparam logic [7:0] TimeoutLimit = 8'(timeout_cycles);

  bus_state_e  state_q;
  logic        last_d_q;
  logic        m_access_q;
  logic [29:0] m_addr_q;
  logic [3:0]  m_bytesel_q;
  logic        m_wr_en_q;
  logic [31:0] m_wr_val_q;
  logic        owner_d_q;

  logic busy;
  logic expired;
  logic resp_ok;
  logic resp_err;
  logic grant_d;
  logic grant_i;

  assign busy = (state_q == StIbus) || (state_q == StDbus);

  // On a tie the requester that did not win last time gets the port.
  assign grant_d = d_access && (!i_access || !last_d_q);
  assign grant_i = i_access && !grant_d;

  // Error beats ack from the slave; a real response beats the watchdog.
  assign resp_ok  = busy && m_ack && !m_error;
  assign resp_err = busy && (m_error || (expired && !m_ack));

  oldland_bus_timeout u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!busy),
    .enable  (busy && !m_ack && !m_error),
    .limit   (TimeoutLimit),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      last_d_q    <= 1'b0;
      m_access_q  <= 1'b0;
      m_addr_q    <= '0;
      m_bytesel_q <= '0;
      m_wr_en_q   <= 1'b0;
      m_wr_val_q  <= '0;
      owner_d_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_d) begin
            state_q     <= StDbus;
            last_d_q    <= 1'b1;
            m_access_q  <= 1'b1;
            m_addr_q    <= d_addr;
            m_bytesel_q <= d_bytesel;
            m_wr_en_q   <= d_wr_en;
            m_wr_val_q  <= d_wr_val;
            owner_d_q   <= 1'b1;
          end else if (grant_i) begin
            state_q     <= StIbus;
            last_d_q    <= 1'b0;
            m_access_q  <= 1'b1;
            m_addr_q    <= i_addr;
            m_bytesel_q <= 4'hf;
            m_wr_en_q   <= 1'b0;
            m_wr_val_q  <= '0;
            owner_d_q   <= 1'b0;
          end
        end
        StIbus, StDbus: begin
          // Requester access is not sampled here: an owned transfer always runs to completion.
          if (resp_ok || resp_err) begin
            state_q    <= StIdle;
            m_access_q <= 1'b0;
            owner_d_q  <= 1'b0;
          end
        end
        default: begin
          state_q    <= StIdle;
          m_access_q <= 1'b0;
          owner_d_q  <= 1'b0;
        end
      endcase
    end
  end

  assign m_access  = m_access_q;
  assign m_addr    = m_addr_q;
  assign m_bytesel = m_bytesel_q;
  assign m_wr_en   = m_wr_en_q;
  assign m_wr_val  = m_wr_val_q;
  assign owner_d   = owner_d_q;

  assign i_data  = m_data;
  assign d_data  = m_data;
  assign i_ack   = resp_ok && (state_q == StIbus);
  assign i_error = resp_err && (state_q == StIbus);
  assign d_ack   = resp_ok && (state_q == StDbus);
  assign d_error = resp_err && (state_q == StDbus);

endmodule

// File: tb/tb_oldland_bus_arbiter.sv
// Directed bench for oldland_bus_arbiter, built with a 4-cycle timeout.
module tb_oldland_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_access;
  logic [29:0] i_addr;
  logic [31:0] i_data;
  logic        i_ack;
  logic        i_error;
  logic        d_access;
  logic [29:0] d_addr;
  logic [3:0]  d_bytesel;
  logic        d_wr_en;
  logic [31:0] d_wr_val;
  logic [31:0] d_data;
  logic        d_ack;
  logic        d_error;
  logic        m_access;
  logic [29:0] m_addr;
  logic [3:0]  m_bytesel;
  logic        m_wr_en;
  logic [31:0] m_wr_val;
  logic [31:0] m_data;
  logic        m_ack;
  logic        m_error;
  logic        owner_d;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  oldland_bus_arbiter #(
    .timeout_cycles (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_access  (i_access),
    .i_addr    (i_addr),
    .i_data    (i_data),
    .i_ack     (i_ack),
    .i_error   (i_error),
    .d_access  (d_access),
    .d_addr    (d_addr),
    .d_bytesel (d_bytesel),
    .d_wr_en   (d_wr_en),
    .d_wr_val  (d_wr_val),
    .d_data    (d_data),
    .d_ack     (d_ack),
    .d_error   (d_error),
    .m_access  (m_access),
    .m_addr    (m_addr),
    .m_bytesel (m_bytesel),
    .m_wr_en   (m_wr_en),
    .m_wr_val  (m_wr_val),
    .m_data    (m_data),
    .m_ack     (m_ack),
    .m_error   (m_error),
    .owner_d   (owner_d)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs driven here apply to this cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    i_access  = 1'b0;
    i_addr    = '0;
    d_access  = 1'b0;
    d_addr    = '0;
    d_bytesel = '0;
    d_wr_en   = 1'b0;
    d_wr_val  = '0;
    m_data    = '0;
    m_ack     = 1'b0;
    m_error   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    #1;
    check_eq("rst m_access", {31'd0, m_access}, 32'd0);
    check_eq("rst m_addr", {2'd0, m_addr}, 32'd0);
    check_eq("rst m_bytesel", {28'd0, m_bytesel}, 32'd0);
    check_eq("rst m_wr_val", m_wr_val, 32'd0);
    check_eq("rst owner_d", {31'd0, owner_d}, 32'd0);
    check_eq("rst acks", {28'd0, i_ack, i_error, d_ack, d_error}, 32'd0);

    // Single data write, slave acks on the third busy cycle.
    d_access  = 1'b1;
    d_addr    = 30'h0000100;
    d_bytesel = 4'b0011;
    d_wr_en   = 1'b1;
    d_wr_val  = 32'hdeadbeef;
    #1;
    check_eq("wr N m_access", {31'd0, m_access}, 32'd0);
    step();
    check_eq("wr m_access", {31'd0, m_access}, 32'd1);
    check_eq("wr m_addr", {2'd0, m_addr}, 32'h100);
    check_eq("wr m_bytesel", {28'd0, m_bytesel}, 32'h3);
    check_eq("wr m_wr_en", {31'd0, m_wr_en}, 32'd1);
    check_eq("wr m_wr_val", m_wr_val, 32'hdeadbeef);
    check_eq("wr owner_d", {31'd0, owner_d}, 32'd1);
    check_eq("wr busy1 d_ack", {31'd0, d_ack}, 32'd0);
    step();
    check_eq("wr busy2 d_ack", {31'd0, d_ack}, 32'd0);
    check_eq("wr busy2 m_addr", {2'd0, m_addr}, 32'h100);
    step();
    m_ack = 1'b1;
    #1;
    check_eq("wr d_ack", {31'd0, d_ack}, 32'd1);
    check_eq("wr i_ack", {31'd0, i_ack}, 32'd0);
    check_eq("wr d_error", {31'd0, d_error}, 32'd0);
    step();
    d_access = 1'b0;
    m_ack    = 1'b0;
    #1;
    check_eq("wr done m_access", {31'd0, m_access}, 32'd0);
    check_eq("wr done d_ack", {31'd0, d_ack}, 32'd0);
    check_eq("wr done owner_d", {31'd0, owner_d}, 32'd0);

    // Ties after reset alternate D, I, D, I with both requests held throughout.
    do_reset();
    i_access  = 1'b1;
    i_addr    = 30'h0000200;
    d_access  = 1'b1;
    d_addr    = 30'h0000300;
    d_bytesel = 4'b0101;
    d_wr_en   = 1'b1;
    d_wr_val  = 32'h11223344;
    for (int r = 0; r < 4; r++) begin
      logic exp_d;
      exp_d = (r % 2) == 0;
      step();
      check_eq($sformatf("tie%0d m_access", r), {31'd0, m_access}, 32'd1);
      check_eq($sformatf("tie%0d owner_d", r), {31'd0, owner_d}, {31'd0, exp_d});
      check_eq($sformatf("tie%0d m_addr", r), {2'd0, m_addr}, exp_d ? 32'h300 : 32'h200);
      check_eq($sformatf("tie%0d m_bytesel", r), {28'd0, m_bytesel}, exp_d ? 32'h5 : 32'hf);
      check_eq($sformatf("tie%0d m_wr_en", r), {31'd0, m_wr_en}, {31'd0, exp_d});
      check_eq($sformatf("tie%0d m_wr_val", r), m_wr_val, exp_d ? 32'h11223344 : 32'h0);
      m_ack  = 1'b1;
      m_data = 32'hcafe0000 + 32'(r);
      #1;
      check_eq($sformatf("tie%0d d_ack", r), {31'd0, d_ack}, {31'd0, exp_d});
      check_eq($sformatf("tie%0d i_ack", r), {31'd0, i_ack}, {31'd0, !exp_d});
      check_eq($sformatf("tie%0d data", r), exp_d ? d_data : i_data, 32'hcafe0000 + 32'(r));
      step();
      m_ack = 1'b0;
      #1;
      check_eq($sformatf("tie%0d idle m_access", r), {31'd0, m_access}, 32'd0);
    end
    i_access = 1'b0;
    d_access = 1'b0;

    // Silent slave: error on the 4th busy cycle, late ack afterwards ignored.
    do_reset();
    i_access = 1'b1;
    i_addr   = 30'h3ffffff;
    for (int c = 1; c <= 4; c++) begin
      step();
      check_eq($sformatf("to busy%0d m_access", c), {31'd0, m_access}, 32'd1);
      check_eq($sformatf("to busy%0d i_error", c), {31'd0, i_error}, {31'd0, c == 4});
      check_eq($sformatf("to busy%0d i_ack", c), {31'd0, i_ack}, 32'd0);
    end
    i_access = 1'b0;
    step();
    check_eq("to drop m_access", {31'd0, m_access}, 32'd0);
    check_eq("to drop i_error", {31'd0, i_error}, 32'd0);
    m_ack = 1'b1;
    #1;
    check_eq("late ack i_ack", {31'd0, i_ack}, 32'd0);
    check_eq("late ack i_error", {31'd0, i_error}, 32'd0);
    check_eq("late ack d_ack", {31'd0, d_ack}, 32'd0);
    step();
    m_ack = 1'b0;
    #1;
    check_eq("late ack no grant", {31'd0, m_access}, 32'd0);

    // Coincident ack and error on a data read: error wins.
    d_access = 1'b1;
    d_addr   = 30'h0000040;
    d_wr_en  = 1'b0;
    step();
    check_eq("ackerr m_wr_en", {31'd0, m_wr_en}, 32'd0);
    m_ack   = 1'b1;
    m_error = 1'b1;
    #1;
    check_eq("ackerr d_error", {31'd0, d_error}, 32'd1);
    check_eq("ackerr d_ack", {31'd0, d_ack}, 32'd0);
    check_eq("ackerr i_error", {31'd0, i_error}, 32'd0);
    step();
    d_access = 1'b0;
    m_ack    = 1'b0;
    m_error  = 1'b0;
    #1;
    check_eq("ackerr m_access", {31'd0, m_access}, 32'd0);

    // Asynchronous reset in the middle of a data transfer, then regrant.
    d_access  = 1'b1;
    d_addr    = 30'h0000abc;
    d_bytesel = 4'b1000;
    d_wr_en   = 1'b1;
    d_wr_val  = 32'h5a5a5a5a;
    step();
    check_eq("mid m_access", {31'd0, m_access}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst m_access", {31'd0, m_access}, 32'd0);
    check_eq("arst m_addr", {2'd0, m_addr}, 32'd0);
    check_eq("arst m_bytesel", {28'd0, m_bytesel}, 32'd0);
    check_eq("arst m_wr_val", m_wr_val, 32'd0);
    check_eq("arst owner_d", {31'd0, owner_d}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    check_eq("arst idle m_access", {31'd0, m_access}, 32'd0);
    step();
    check_eq("regrant m_access", {31'd0, m_access}, 32'd1);
    check_eq("regrant m_addr", {2'd0, m_addr}, 32'habc);
    check_eq("regrant m_wr_val", m_wr_val, 32'h5a5a5a5a);
    m_ack  = 1'b1;
    m_data = 32'h87654321;
    #1;
    check_eq("regrant d_ack", {31'd0, d_ack}, 32'd1);
    check_eq("regrant d_data", d_data, 32'h87654321);
    step();
    d_access = 1'b0;
    m_ack    = 1'b0;
    #1;
    check_eq("regrant done", {31'd0, m_access}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
